// File: rtl/mips_pkg.sv
// Shared MIPS definitions: load/store opcodes and data-memory port FSM states.
package mips_pkg;

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LWL = 6'b100010;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_LWR = 6'b100110;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } mem_state_t;

endpackage

// File: rtl/load_align.sv
// Load result formatting: lane extraction with sign/zero extension and LWL/LWR merge.
// Purely combinational; unknown opcodes return the full word.
module load_align
    import mips_pkg::*;
(
    input  logic [5:0]  opcode,
    input  logic [1:0]  offset,
    input  logic [31:0] rdata,
    input  logic [31:0] rt_old,
    output logic [31:0] load_data
);

    logic [15:0] lane;
    logic [4:0]  shl_amt;
    logic [4:0]  shr_amt;

    always_comb begin
        lane      = 16'(rdata >> {offset, 3'b000});
        shl_amt   = {~offset, 3'b000};   // 8*(3-k)
        shr_amt   = {offset, 3'b000};
        load_data = rdata;
        case (opcode)
            OP_LB:   load_data = {{24{lane[7]}}, lane[7:0]};
            OP_LBU:  load_data = {24'h0, lane[7:0]};
            OP_LH:   load_data = {{16{lane[15]}}, lane};
            OP_LHU:  load_data = {16'h0, lane};
            OP_LWL:  load_data = (rdata << shl_amt) | (rt_old & ((32'h1 << shl_amt) - 32'h1));
            OP_LWR:  load_data = (rdata >> shr_amt) | (rt_old & ~(32'hFFFF_FFFF >> shr_amt));
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/data_mem_port.sv
// Load/store responder: one waitrequest bus transaction per load/store, stalling the core.
// Latency 3 cycles minimum, +1 per waitrequest cycle; mem_* outputs held while waitrequest is high.
module data_mem_port
    import mips_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              memread,
    input  logic              memwrite,
    input  logic [5:0]        insop,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] rt_data,
    output logic              stall,
    output logic [DATA_W-1:0] load_data,
    output logic              load_valid,
    output logic              addr_error,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    output logic              mem_write,
    output logic [3:0]        mem_byteenable,
    output logic [DATA_W-1:0] mem_writedata,
    input  logic [DATA_W-1:0] mem_readdata,
    input  logic              mem_waitrequest
);

    mem_state_t        state_q, state_d;
    logic [5:0]        op_d, op_q;
    logic              misaligned;
    logic [3:0]        be_d;
    logic [DATA_W-1:0] wdata_d;
    logic              start;
    logic [1:0]        off_q;
    logic [DATA_W-1:0] rt_q, rdata_q, last_q, align_out;
    logic              is_load_q;

    // Opcode normalisation: memread wins, unknown opcodes become LW/SW.
    always_comb begin
        op_d       = OP_LW;
        misaligned = 1'b0;
        be_d       = 4'b1111;
        wdata_d    = rt_data;
        if (memread) begin
            case (insop)
                OP_LB, OP_LBU, OP_LWL, OP_LWR: op_d = insop;
                OP_LH, OP_LHU: begin
                    op_d       = insop;
                    misaligned = addr[0];
                end
                default: begin
                    op_d       = OP_LW;
                    misaligned = |addr[1:0];
                end
            endcase
        end else begin
            case (insop)
                OP_SB: begin
                    op_d    = OP_SB;
                    be_d    = 4'b0001 << addr[1:0];
                    wdata_d = {4{rt_data[7:0]}};
                end
                OP_SH: begin
                    op_d       = OP_SH;
                    misaligned = addr[0];
                    be_d       = 4'b0011 << addr[1:0];
                    wdata_d    = {2{rt_data[15:0]}};
                end
                default: begin
                    op_d       = OP_SW;
                    misaligned = |addr[1:0];
                end
            endcase
        end
    end

    always_comb begin
        state_d    = state_q;
        stall      = 1'b0;
        start      = 1'b0;
        addr_error = 1'b0;
        case (state_q)
            IDLE: begin
                if ((memread | memwrite) && misaligned) begin
                    addr_error = 1'b1;
                end else if (memread | memwrite) begin
                    stall   = 1'b1;
                    start   = 1'b1;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                stall = 1'b1;
                if (!mem_waitrequest) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            op_q           <= '0;
            off_q          <= '0;
            rt_q           <= '0;
            is_load_q      <= 1'b0;
            rdata_q        <= '0;
            last_q         <= '0;
            mem_address    <= '0;
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
            mem_byteenable <= '0;
            mem_writedata  <= '0;
        end else begin
            state_q <= state_d;
            if (start) begin
                op_q           <= op_d;
                off_q          <= addr[1:0];
                rt_q           <= rt_data;
                is_load_q      <= memread;
                mem_address    <= {addr[ADDR_W-1:2], 2'b00};
                mem_read       <= memread;
                mem_write      <= ~memread;
                mem_byteenable <= be_d;
                mem_writedata  <= wdata_d;
            end
            if (state_q == ACCESS && !mem_waitrequest) begin
                if (mem_read) rdata_q <= mem_readdata;
                mem_read  <= 1'b0;
                mem_write <= 1'b0;
            end
            if (load_valid) last_q <= align_out;
        end
    end

    load_align u_load_align (
        .opcode    (op_q),
        .offset    (off_q),
        .rdata     (rdata_q),
        .rt_old    (rt_q),
        .load_data (align_out)
    );

    assign load_valid = (state_q == DONE) && is_load_q;
    assign load_data  = load_valid ? align_out : last_q;

endmodule

// File: tb/tb_data_mem_port.sv
// Self-checking bench for data_mem_port: vector table driven through a scoreboard, plus reset corner case.
module tb_data_mem_port;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        memread, memwrite;
    logic [5:0]  insop;
    logic [31:0] addr, rt_data;
    logic        stall, load_valid, addr_error;
    logic [31:0] load_data, mem_address, mem_writedata, mem_readdata;
    logic        mem_read, mem_write, mem_waitrequest;
    logic [3:0]  mem_byteenable;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          rd;
        bit          wr;
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] rt;
        logic [31:0] rdata;
        int          waits;
        bit          err;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] ld;
    } vec_t;

    typedef struct {
        logic [31:0] maddr;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] ld;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];

    data_mem_port dut (
        .clk(clk), .rst_n(rst_n), .memread(memread), .memwrite(memwrite),
        .insop(insop), .addr(addr), .rt_data(rt_data), .stall(stall),
        .load_data(load_data), .load_valid(load_valid), .addr_error(addr_error),
        .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
        .mem_byteenable(mem_byteenable), .mem_writedata(mem_writedata),
        .mem_readdata(mem_readdata), .mem_waitrequest(mem_waitrequest)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(bit rd, bit wr, logic [5:0] op, logic [31:0] a, logic [31:0] rt,
                                logic [31:0] rdata, int waits, bit err, logic [3:0] be,
                                logic [31:0] wd, logic [31:0] ld);
        vec_t v;
        v.rd = rd; v.wr = wr; v.op = op; v.a = a; v.rt = rt; v.rdata = rdata;
        v.waits = waits; v.err = err; v.be = be; v.wd = wd; v.ld = ld;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        int   cyc;
        int   acc;
        bit   done;
        exp_t e;
        @(negedge clk);
        memread = v.rd; memwrite = v.wr; insop = v.op; addr = v.a; rt_data = v.rt;
        mem_waitrequest = 1'b0; mem_readdata = 32'h5A5A_5A5A;
        #1;
        if (v.err) begin
            chk($sformatf("v%0d addr_error", idx), {31'b0, addr_error}, 32'd1);
            chk($sformatf("v%0d err_stall", idx), {31'b0, stall}, 32'd0);
            @(posedge clk); #1;
            chk($sformatf("v%0d err_no_strobe", idx), {30'b0, mem_read, mem_write}, 32'd0);
            @(negedge clk);
            memread = 1'b0; memwrite = 1'b0;
            #1;
            chk($sformatf("v%0d err_pulse_end", idx), {31'b0, addr_error}, 32'd0);
            chk($sformatf("v%0d err_idle_strobe", idx), {30'b0, mem_read, mem_write}, 32'd0);
            return;
        end
        chk($sformatf("v%0d idle_stall", idx), {31'b0, stall}, 32'd1);
        chk($sformatf("v%0d idle_noerr", idx), {31'b0, addr_error}, 32'd0);
        e.maddr = {v.a[31:2], 2'b00}; e.be = v.be; e.wd = v.wd; e.ld = v.ld;
        exp_q.push_back(e);
        cyc = 1; acc = 0; done = 0;
        for (int t = 0; t < 64 && !done; t++) begin
            @(negedge clk);
            cyc++;
            if (stall) begin
                chk($sformatf("v%0d strobe", idx), {30'b0, mem_read, mem_write},
                    v.rd ? 32'd2 : 32'd1);
                chk($sformatf("v%0d mem_address", idx), mem_address, exp_q[0].maddr);
                chk($sformatf("v%0d byteenable", idx), {28'b0, mem_byteenable}, {28'b0, exp_q[0].be});
                if (!v.rd) chk($sformatf("v%0d writedata", idx), mem_writedata, exp_q[0].wd);
                mem_waitrequest = (acc < v.waits);
                mem_readdata    = (acc < v.waits) ? 32'h5A5A_5A5A : v.rdata;
                acc++;
            end else begin
                done = 1;
                chk($sformatf("v%0d latency", idx), cyc, 3 + v.waits);
                chk($sformatf("v%0d done_strobe", idx), {30'b0, mem_read, mem_write}, 32'd0);
                chk($sformatf("v%0d load_valid", idx), {31'b0, load_valid}, {31'b0, v.rd});
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL v%0d scoreboard: got empty queue expected entry", idx);
                end else begin
                    e = exp_q.pop_front();
                    if (v.rd) chk($sformatf("v%0d load_data", idx), load_data, e.ld);
                end
                memread = 1'b0; memwrite = 1'b0; mem_waitrequest = 1'b0;
            end
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL v%0d timeout: got stall stuck expected completion", idx);
            memread = 1'b0; memwrite = 1'b0; mem_waitrequest = 1'b0;
            exp_q.delete();
        end
        @(negedge clk);
        chk($sformatf("v%0d after_valid", idx), {31'b0, load_valid}, 32'd0);
        chk($sformatf("v%0d after_stall", idx), {31'b0, stall}, 32'd0);
        if (v.rd) chk($sformatf("v%0d load_hold", idx), load_data, v.ld);
    endtask

    initial begin
        rst_n = 1'b0; memread = 1'b0; memwrite = 1'b0; insop = '0; addr = '0; rt_data = '0;
        mem_readdata = '0; mem_waitrequest = 1'b0;

        //            rd wr op      addr        rt            rdata         w  err be       wd            ld
        vecs.push_back(mk(0, 1, OP_SW,  32'h100, 32'hDEADBEEF, 32'h0,        0, 0, 4'b1111, 32'hDEADBEEF, 32'h0));
        vecs.push_back(mk(1, 0, OP_LB,  32'h203, 32'h0,        32'h80FF1234, 3, 0, 4'b1111, 32'h0,        32'hFFFFFF80));
        vecs.push_back(mk(0, 1, OP_SH,  32'h102, 32'h0000ABCD, 32'h0,        0, 0, 4'b1100, 32'hABCDABCD, 32'h0));
        vecs.push_back(mk(1, 0, OP_LHU, 32'h102, 32'h0,        32'hABCD0000, 0, 0, 4'b1111, 32'h0,        32'h0000ABCD));
        vecs.push_back(mk(1, 0, OP_LW,  32'h101, 32'h0,        32'h0,        0, 1, 4'b0000, 32'h0,        32'h0));
        vecs.push_back(mk(1, 0, OP_LH,  32'h103, 32'h0,        32'h0,        0, 1, 4'b0000, 32'h0,        32'h0));
        vecs.push_back(mk(1, 0, OP_LWL, 32'h1,   32'h11223344, 32'hAABBCCDD, 0, 0, 4'b1111, 32'h0,        32'hCCDD3344));
        vecs.push_back(mk(1, 0, OP_LWR, 32'h1,   32'h11223344, 32'hAABBCCDD, 0, 0, 4'b1111, 32'h0,        32'h11AABBCC));
        vecs.push_back(mk(0, 1, OP_SB,  32'h201, 32'h12345678, 32'h0,        0, 0, 4'b0010, 32'h78787878, 32'h0));
        vecs.push_back(mk(1, 0, OP_LBU, 32'h202, 32'h0,        32'h80FF1234, 1, 0, 4'b1111, 32'h0,        32'h000000FF));
        vecs.push_back(mk(1, 0, OP_LH,  32'h100, 32'h0,        32'h1234F00D, 0, 0, 4'b1111, 32'h0,        32'hFFFFF00D));
        vecs.push_back(mk(1, 0, OP_LW,  32'h104, 32'h0,        32'hCAFEBABE, 2, 0, 4'b1111, 32'h0,        32'hCAFEBABE));
        vecs.push_back(mk(1, 0, OP_LWL, 32'h3,   32'h11223344, 32'hAABBCCDD, 0, 0, 4'b1111, 32'h0,        32'hAABBCCDD));
        vecs.push_back(mk(1, 0, OP_LWR, 32'h3,   32'h11223344, 32'hAABBCCDD, 0, 0, 4'b1111, 32'h0,        32'h112233AA));
        vecs.push_back(mk(1, 0, OP_LWL, 32'h0,   32'h11223344, 32'hAABBCCDD, 0, 0, 4'b1111, 32'h0,        32'hDD223344));
        vecs.push_back(mk(0, 1, OP_SW,  32'h102, 32'h1,        32'h0,        0, 1, 4'b0000, 32'h0,        32'h0));
        vecs.push_back(mk(1, 1, OP_SW,  32'h108, 32'h0,        32'h01020304, 0, 0, 4'b1111, 32'h0,        32'h01020304));
        vecs.push_back(mk(0, 1, 6'b0,   32'h10C, 32'h55667788, 32'h0,        0, 0, 4'b1111, 32'h55667788, 32'h0));
        vecs.push_back(mk(0, 1, OP_SH,  32'h200, 32'h9999BEEF, 32'h0,        1, 0, 4'b0011, 32'hBEEFBEEF, 32'h0));
        vecs.push_back(mk(1, 0, OP_LB,  32'h0,   32'h0,        32'h0000007F, 0, 0, 4'b1111, 32'h0,        32'h0000007F));
        vecs.push_back(mk(0, 1, OP_SB,  32'h3,   32'h000000AB, 32'h0,        0, 0, 4'b1000, 32'hABABABAB, 32'h0));

        #12;
        chk("reset_stall", {31'b0, stall}, 32'd0);
        chk("reset_strobes", {30'b0, mem_read, mem_write}, 32'd0);
        chk("reset_load_data", load_data, 32'd0);
        chk("reset_valid_err", {30'b0, load_valid, addr_error}, 32'd0);
        chk("reset_mem_address", mem_address, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Reset asserted mid-transaction while the bus is stalling.
        @(negedge clk);
        memread = 1'b1; memwrite = 1'b0; insop = OP_LW; addr = 32'h300; mem_waitrequest = 1'b1;
        @(negedge clk);
        chk("rst_access_read", {31'b0, mem_read}, 32'd1);
        @(negedge clk);
        rst_n = 1'b0; memread = 1'b0;
        #1;
        chk("rst_async_stall", {31'b0, stall}, 32'd0);
        chk("rst_async_strobe", {30'b0, mem_read, mem_write}, 32'd0);
        chk("rst_async_addr", mem_address, 32'd0);
        chk("rst_async_be", {28'b0, mem_byteenable}, 32'd0);
        chk("rst_async_load", load_data, 32'd0);
        chk("rst_async_valid", {31'b0, load_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1; mem_waitrequest = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_after_strobe", {30'b0, mem_read, mem_write}, 32'd0);
        chk("rst_after_stall", {31'b0, stall}, 32'd0);
        run_vec(vecs[0], 100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
